auction_bid_collector: RTL

Sequential front end for the combinational auction tree. It accepts one bid per cycle from 2**N bidders over a valid/ready handshake and records which bidders have submitted. It closes the round when every bidder has bid or when `close` is asserted, then holds the packed `bid` vector stable for the downstream auction until it is acknowledged. Bidders that never submitted are presented as bid 0.

---
 rtl/auction_bid_collector_if.sv | 31 +++
 rtl/auction_bid_collector.sv | 126 ++++++++++++
 2 files changed

// File: rtl/auction_bid_collector_if.sv
// Bus between the bidders, the auction bid collector and the downstream auction.
//   master : drives in_valid/in_id/in_bid/close/bid_ack and observes the collector.
//   slave  : the collector; drives in_ready, bid, bid_valid, submitted, count, dup_err.
interface auction_bid_collector_if #(
    parameter int N = 2,
    parameter int W = 2
);
    localparam int NB = 1 << N;

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_id;
    logic [W-1:0]      in_bid;
    logic              close;
    logic [NB*W-1:0]   bid;
    logic              bid_valid;
    logic              bid_ack;
    logic [NB-1:0]     submitted;
    logic [N:0]        count;
    logic              dup_err;

    modport master (
        output in_valid, in_id, in_bid, close, bid_ack,
        input  in_ready, bid, bid_valid, submitted, count, dup_err
    );

    modport slave (
        input  in_valid, in_id, in_bid, close, bid_ack,
        output in_ready, bid, bid_valid, submitted, count, dup_err
    );
endinterface

// File: rtl/auction_bid_collector.sv
// Auction bid collector: gathers one bid per cycle from 2**N bidders, closes the
// round when every bidder has bid or on close, then holds the packed bid vector
// until bid_ack.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : auction_bid_collector_if.slave (bid handshake, close, packed result,
//          submitted mask, count, dup_err pulse, bid_ack)

// One bidder lane: stores that bidder's bid and whether it has been recorded.
module auction_bid_slot #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] q,
    output logic         set
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q   <= '0;
            set <= 1'b0;
        end else if (wr_en) begin
            q   <= wr_data;
            set <= 1'b1;
        end
    end
endmodule

module auction_bid_collector #(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    auction_bid_collector_if.slave  bus
);
    localparam int NB = 1 << N;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    typedef struct packed {
        logic [N-1:0] id;
        logic [W-1:0] val;
    } bid_req_t;

    state_t                  state_q, state_d;
    bid_req_t                req;
    logic [NB-1:0][W-1:0]    slot_q;
    logic [NB-1:0]           sub_q;
    logic [NB-1:0]           lane_wr;
    logic [N:0]              count_q, count_d;
    logic                    dup_q;
    logic                    accept, dup, acc_new, round_clr;

    assign req = {bus.in_id, bus.in_bid};

    // in_ready is 1 exactly in COLLECT, so an offer there is always taken.
    assign accept    = (state_q == S_COLLECT) && bus.in_valid;
    assign dup       = accept && sub_q[req.id];
    assign acc_new   = accept && !sub_q[req.id];
    assign round_clr = (state_q == S_HOLD) && bus.bid_ack;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign lane_wr[i] = acc_new && (req.id == N'(i));

        auction_bid_slot #(.W(W)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr     (round_clr),
            .wr_en   (lane_wr[i]),
            .wr_data (req.val),
            .q       (slot_q[i]),
            .set     (sub_q[i])
        );
    end

    always_comb begin
        count_d = count_q;
        if (round_clr)
            count_d = '0;
        else if (acc_new)
            count_d = count_q + (N+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_COLLECT;
            count_q <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dup_q   <= dup;
        end
    end

    // A same-cycle accept is applied by the lanes before the close takes effect,
    // so the bid that arrives with close is part of the held result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: begin
                if ((acc_new && (count_q == (N+1)'(NB-1))) || bus.close)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.bid_ack)
                    state_d = S_COLLECT;
            end
            default: state_d = S_COLLECT;
        endcase
    end

    assign bus.in_ready  = (state_q == S_COLLECT);
    assign bus.bid_valid = (state_q == S_HOLD);
    assign bus.bid       = slot_q;
    assign bus.submitted = sub_q;
    assign bus.count     = count_q;
    assign bus.dup_err   = dup_q;
endmodule
